// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational MIPS ALU between two requesters.
// A round-robin grant is made in IDLE, the winning operands are registered
// onto the ALU inputs, the ALU result is captured one cycle later and held
// on a single response channel until the consumer accepts it.
//
// Optional feature: define ALU_SHARE_ARBITER_STATS_EN to add per-requester
// saturating completion counters (stat_cnt0/stat_cnt1) and a synchronous
// stat_clear input.
//
// Ports:
//   CLK, RESETN              clock, asynchronous active-low reset
//   reqN_valid/ready         requester N handshake (ready is combinational)
//   reqN_a/b/op              requester N operands and aluop
//   alu_a/alu_b/alu_op       registered ALU inputs
//   alu_result/alu_zero      ALU outputs, sampled in EXEC
//   rsp_valid/ready          response handshake
//   rsp_id/result/zero       response owner, captured result and zero flag
//   stat_cnt0/1, stat_clear  (stats build only) completion counters
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OP_W-1:0]  req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OP_W-1:0]  req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
`ifdef ALU_SHARE_ARBITER_STATS_EN
   output logic [CNT_W-1:0] stat_cnt0,
   output logic [CNT_W-1:0] stat_cnt1,
   input  logic             stat_clear,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             ptr_r;
   logic             gnt0_s;
   logic             gnt1_s;
   logic             v0_s;
   logic             v1_s;
   logic             accept_s;
   logic             handshake_s;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [OP_W-1:0]  alu_op_r;
   logic [WIDTH-1:0] rsp_result_r;
   logic             rsp_zero_r;
   logic             rsp_id_r;
   logic             rsp_valid_r;

   // Valids are masked by reset so no ready is offered while RESETN is low.
   assign v0_s        = req0_valid & RESETN;
   assign v1_s        = req1_valid & RESETN;
   assign accept_s    = gnt0_s | gnt1_s;
   assign handshake_s = rsp_valid_r & rsp_ready;

   // Round-robin grant and next-state decode.
   always_comb begin
      gnt0_s      = 1'b0;
      gnt1_s      = 1'b0;
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (v0_s && v1_s) begin
               if (ptr_r) begin
                  gnt1_s = 1'b1;
               end else begin
                  gnt0_s = 1'b1;
               end
            end else if (v0_s) begin
               gnt0_s = 1'b1;
            end else if (v1_s) begin
               gnt1_s = 1'b1;
            end else begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
            if (gnt0_s || gnt1_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_nxt_s = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch, owner id and pointer update; all only on an accept so the
   // ALU inputs stay frozen for the whole operation.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         alu_a_r  <= {WIDTH{1'b0}};
         alu_b_r  <= {WIDTH{1'b0}};
         alu_op_r <= {OP_W{1'b0}};
         rsp_id_r <= 1'b0;
         ptr_r    <= 1'b0;
      end else if (accept_s) begin
         alu_a_r  <= gnt1_s ? req1_a  : req0_a;
         alu_b_r  <= gnt1_s ? req1_b  : req0_b;
         alu_op_r <= gnt1_s ? req1_op : req0_op;
         rsp_id_r <= gnt1_s;
         ptr_r    <= ~gnt1_s;
      end
   end

   // Result capture at the end of EXEC and response-valid tracking.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rsp_result_r <= {WIDTH{1'b0}};
         rsp_zero_r   <= 1'b0;
         rsp_valid_r  <= 1'b0;
      end else if (state_r == ST_EXEC) begin
         rsp_result_r <= alu_result;
         rsp_zero_r   <= alu_zero;
         rsp_valid_r  <= 1'b1;
      end else if (handshake_s) begin
         rsp_valid_r  <= 1'b0;
      end
   end

   assign req0_ready = gnt0_s;
   assign req1_ready = gnt1_s;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign alu_op     = alu_op_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_result = rsp_result_r;
   assign rsp_zero   = rsp_zero_r;

`ifdef ALU_SHARE_ARBITER_STATS_EN
   logic [CNT_W-1:0] cnt0_r;
   logic [CNT_W-1:0] cnt1_r;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturating completion counters; clear wins over a same-cycle completion.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt0_r <= {CNT_W{1'b0}};
         cnt1_r <= {CNT_W{1'b0}};
      end else if (stat_clear) begin
         cnt0_r <= {CNT_W{1'b0}};
         cnt1_r <= {CNT_W{1'b0}};
      end else if (handshake_s) begin
         if (!rsp_id_r && !(&cnt0_r)) begin
            cnt0_r <= cnt0_r + CNT_ONE;
         end
         if (rsp_id_r && !(&cnt1_r)) begin
            cnt1_r <= cnt1_r + CNT_ONE;
         end
      end
   end

   assign stat_cnt0 = cnt0_r;
   assign stat_cnt1 = cnt1_r;
`else
   // Keeps CNT_W referenced in builds without the counters.
   logic [CNT_W-1:0] unused_cnt_s;
   assign unused_cnt_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   localparam int WIDTH = 32;
   localparam int OP_W  = 4;
`ifdef ALU_SHARE_ARBITER_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic             CLK;
   logic             RESETN;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OP_W-1:0]  req0_op, req1_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [OP_W-1:0]  alu_op;
   logic             alu_zero;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [WIDTH-1:0] rsp_result;
`ifdef ALU_SHARE_ARBITER_STATS_EN
   logic [CNT_W-1:0] stat_cnt0, stat_cnt1;
   logic             stat_clear;
`endif

   int vectors = 0;
   int miscompares = 0;

   alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
`ifdef ALU_SHARE_ARBITER_STATS_EN
      .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_clear(stat_clear),
`endif
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   // External ALU stand-in: 0000 add, 0010 sub, 1010 slt, others AND.
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0010: alu_result = alu_a - alu_b;
         4'b1010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_result = alu_a & alu_b;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic test_reset;
      RESETN = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
      req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
`ifdef ALU_SHARE_ARBITER_STATS_EN
      stat_clear = 1'b0;
`endif
      #2;
      vectors++;
      if ({alu_a, alu_b, alu_op} !== {32'd0, 32'd0, 4'd0}) begin
         miscompares++;
         $display("FAIL reset_alu: got a=%0h b=%0h op=%0h expected 0 0 0", alu_a, alu_b, alu_op);
      end
      vectors++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready} !== {3'b000, 32'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL reset_rsp: got v=%b id=%b z=%b r=%0h rdy=%b%b expected all 0",
                  rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready);
      end
      @(negedge CLK); RESETN = 1'b1;
   endtask

   task automatic test_req0_only;
      @(negedge CLK);
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0000; rsp_ready = 1'b1;
      #1; vectors++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL req0_grant: got rdy=%b%b expected 10", req0_ready, req1_ready);
      end
      @(negedge CLK); req0_valid = 1'b0; #1; vectors++;
      if ({alu_a, alu_b, alu_op, rsp_valid, req0_ready} !== {32'd5, 32'd3, 4'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL req0_exec: got a=%0h b=%0h op=%0h v=%b rdy=%b expected 5 3 0 0 0",
                  alu_a, alu_b, alu_op, rsp_valid, req0_ready);
      end
      @(negedge CLK); #1; vectors++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {3'b100, 32'd8}) begin
         miscompares++;
         $display("FAIL req0_rsp: got v=%b id=%b z=%b r=%0h expected 1 0 0 8",
                  rsp_valid, rsp_id, rsp_zero, rsp_result);
      end
      @(negedge CLK); #1; vectors++;
      if (rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL req0_done: got v=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_req1_only;
      @(negedge CLK);
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 4'b0010;
      #1; vectors++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL req1_grant: got rdy=%b%b expected 01", req0_ready, req1_ready);
      end
      @(negedge CLK); req1_valid = 1'b0;
      @(negedge CLK); #1; vectors++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {3'b111, 32'd0}) begin
         miscompares++;
         $display("FAIL req1_rsp: got v=%b id=%b z=%b r=%0h expected 1 1 1 0",
                  rsp_valid, rsp_id, rsp_zero, rsp_result);
      end
      @(negedge CLK);
   endtask

   // Pointer is 0 here (last grant went to requester 1).
   task automatic test_back_to_back;
      logic             exp_id;
      logic [WIDTH-1:0] exp_res;
      req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b1010;
      req1_a = 32'd2; req1_b = 32'd1; req1_op = 4'b1010;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_id  = (k % 2) == 1;
         exp_res = exp_id ? 32'd0 : 32'd1;
         @(negedge CLK); req0_valid = 1'b1; req1_valid = 1'b1; #1; vectors++;
         if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
            miscompares++;
            $display("FAIL b2b_grant%0d: got rdy=%b%b expected %b%b", k,
                     req0_ready, req1_ready, ~exp_id, exp_id);
         end
         @(negedge CLK); #1; vectors++;
         if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL b2b_exec%0d: got rdy=%b%b v=%b expected 000", k,
                     req0_ready, req1_ready, rsp_valid);
         end
         @(negedge CLK); #1; vectors++;
         if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, exp_id, exp_id, exp_res}) begin
            miscompares++;
            $display("FAIL b2b_rsp%0d: got v=%b id=%b z=%b r=%0h expected 1 %b %b %0h", k,
                     rsp_valid, rsp_id, rsp_zero, rsp_result, exp_id, exp_id, exp_res);
         end
      end
      @(negedge CLK); req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   // Pointer is 0 again; requester 0 wins, then requester 1 after release.
   task automatic test_stall;
      rsp_ready = 1'b0;
      req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'b0000;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge CLK);
      @(negedge CLK); #1; vectors++;
      if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd30}) begin
         miscompares++;
         $display("FAIL stall_rsp: got v=%b id=%b r=%0h expected 1 0 1e", rsp_valid, rsp_id, rsp_result);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         req0_a = 32'd100 + k; req1_a = 32'd200 + k; req0_op = 4'b0010;
         #1; vectors++;
         if ({rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready, alu_a, alu_op}
             !== {3'b100, 32'd30, 2'b00, 32'd10, 4'd0}) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got v=%b id=%b r=%0h rdy=%b%b alu_a=%0h op=%0h expected 1 0 1e 00 a 0",
                     k, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready, alu_a, alu_op);
         end
      end
      @(negedge CLK); rsp_ready = 1'b1;
      @(negedge CLK); #1; vectors++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL stall_release: got v=%b rdy=%b%b expected 0 01", rsp_valid, req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   // Pointer is 1 before the reset; it must come back as 0.
   task automatic test_reset_mid_op;
      @(negedge CLK);
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_op = 4'b0000;
      @(negedge CLK);
      req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = 4'b0000;
      #1; RESETN = 1'b0; #1; vectors++;
      if ({rsp_valid, alu_a, req0_ready, req1_ready} !== {1'b0, 32'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL midrst_async: got v=%b alu_a=%0h rdy=%b%b expected 0 0 00",
                  rsp_valid, alu_a, req0_ready, req1_ready);
      end
      @(negedge CLK); #1; vectors++;
      if (rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_norsp: got v=%b expected 0", rsp_valid);
      end
      @(negedge CLK); RESETN = 1'b1; #1; vectors++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL midrst_ptr: got rdy=%b%b expected 10", req0_ready, req1_ready);
      end
      @(negedge CLK); req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge CLK); #1; vectors++;
      if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd10}) begin
         miscompares++;
         $display("FAIL midrst_rsp: got v=%b id=%b r=%0h expected 1 0 a", rsp_valid, rsp_id, rsp_result);
      end
      @(negedge CLK);
   endtask

`ifdef ALU_SHARE_ARBITER_STATS_EN
   task automatic test_stats;
      @(negedge CLK); stat_clear = 1'b1;
      @(negedge CLK); stat_clear = 1'b0;
      req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0000; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK); req0_valid = 1'b1;
         @(negedge CLK); req0_valid = 1'b0;
         @(negedge CLK);
      end
      @(negedge CLK); #1; vectors++;
      if ({stat_cnt0, stat_cnt1} !== {2'd3, 2'd0}) begin
         miscompares++;
         $display("FAIL stats_sat: got cnt0=%0d cnt1=%0d expected 3 0", stat_cnt0, stat_cnt1);
      end
      stat_clear = 1'b1;
      @(negedge CLK); stat_clear = 1'b0; #1; vectors++;
      if ({stat_cnt0, stat_cnt1} !== {2'd0, 2'd0}) begin
         miscompares++;
         $display("FAIL stats_clear: got cnt0=%0d cnt1=%0d expected 0 0", stat_cnt0, stat_cnt1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_req0_only();
      test_req1_only();
      test_back_to_back();
      test_stall();
      test_reset_mid_op();
`ifdef ALU_SHARE_ARBITER_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
